ysyx_040066_mcsr: RTL

Parametrised machine-mode CSR unit, successor to the single-width CSR file in the CPU/CSR directory. Sits beside the execute/writeback stage. Integrates:
- CSR read/modify/write
- trap entry and `mret`
- free-running `mcycle`/`minstret` counters
- synchronised external interrupt lines with priority arbitration
- direct or vectored `mtvec` redirect

---
 rtl/ysyx_040066_csr_pkg.sv | 64 ++++++
 rtl/ysyx_040066_sync2.sv | 34 +++
 rtl/ysyx_040066_mcsr.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_040066_csr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_040066_csr_pkg
// Description : Shared constants for the machine-mode CSR unit. Holds the CSR
//               addresses, the write-operation encodings, the interrupt cause
//               codes and their priority order, the mstatus field positions,
//               and the mstatus reset images for XLEN = 32 and XLEN = 64.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_040066_csr_pkg;

   // CSR addresses
   localparam logic [11:0] C_CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] C_CSR_MIE       = 12'h304;
   localparam logic [11:0] C_CSR_MTVEC     = 12'h305;
   localparam logic [11:0] C_CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] C_CSR_MEPC      = 12'h341;
   localparam logic [11:0] C_CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] C_CSR_MTVAL     = 12'h343;
   localparam logic [11:0] C_CSR_MIP       = 12'h344;
   localparam logic [11:0] C_CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] C_CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] C_CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] C_CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] C_CSR_MHARTID   = 12'hF14;

   // CSR write operations
   typedef enum logic [1:0] {
      CSR_OP_NOP = 2'b00,
      CSR_OP_RW  = 2'b01,
      CSR_OP_RS  = 2'b10,
      CSR_OP_RC  = 2'b11
   } csr_op_e;

   // Interrupt cause codes (also the bit positions in mip/mie)
   localparam logic [3:0] C_IRQ_MSI = 4'd3;
   localparam logic [3:0] C_IRQ_MTI = 4'd7;
   localparam logic [3:0] C_IRQ_MEI = 4'd11;
   localparam logic [11:0] C_IRQ_MASK = 12'h888;

   // mstatus field positions
   localparam int C_MSTATUS_MIE    = 3;
   localparam int C_MSTATUS_MPIE   = 7;
   localparam int C_MSTATUS_MPP_LO = 11;
   localparam int C_MSTATUS_MPP_HI = 12;
   localparam logic [63:0] C_MSTATUS_WMASK = 64'h0000_0000_0000_1888;

   // mstatus reset images (UXL/SXL = 10 only exist for XLEN = 64)
   localparam logic [63:0] C_MSTATUS_RST64 = 64'h0000_000A_0000_1800;
   localparam logic [63:0] C_MSTATUS_RST32 = 64'h0000_0000_0000_1800;

   // Picks the winning interrupt code from a pending vector.
   // Priority order is MEI > MSI > MTI; later assignments win.
   function automatic logic [3:0] irq_pick(input logic [11:0] pend);
      logic [3:0] code;
      code = 4'd0;
      if (pend[C_IRQ_MTI]) code = C_IRQ_MTI;
      if (pend[C_IRQ_MSI]) code = C_IRQ_MSI;
      if (pend[C_IRQ_MEI]) code = C_IRQ_MEI;
      return code;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_040066_sync2.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_040066_sync2
// Description : Two-flop synchroniser for a single asynchronous level input.
// Ports       : clk  - sampling clock
//               rst  - asynchronous active-low reset (flops clear to 0)
//               i_d  - asynchronous input
//               o_q  - synchronised output, two edges behind i_d
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_040066_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/ysyx_040066_mcsr.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_040066_mcsr
// Description : Machine-mode CSR unit: CSR read/modify/write with read bypass,
//               trap entry and mret, 64-bit mcycle/minstret, synchronised
//               external interrupts with priority arbitration and a direct or
//               vectored mtvec redirect.
// Ports       : clk, rst (async active-low)
//               rd_addr/rd_data/rd_illegal            - combinational CSR read
//               wr_en/wr_addr/wr_op/wr_src/wr_illegal - CSR write
//               trap/trap_cause/trap_tval/trap_pc     - trap entry
//               mret, retire                          - return / retire strobes
//               ext_meip/ext_mtip/ext_msip            - async interrupt lines
//               irq_take/irq_cause                    - interrupt request
//               redirect/redirect_pc                  - PC redirect
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_040066_mcsr
   import ysyx_040066_csr_pkg::*;
#(
   parameter int          XLEN     = 64,
   parameter int unsigned HART_ID  = 0,
   parameter bit          VECTORED = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [11:0]     rd_addr,
   output logic [XLEN-1:0] rd_data,
   output logic            rd_illegal,
   input  logic            wr_en,
   input  logic [11:0]     wr_addr,
   input  logic [1:0]      wr_op,
   input  logic [XLEN-1:0] wr_src,
   output logic            wr_illegal,
   input  logic            trap,
   input  logic [XLEN-1:0] trap_cause,
   input  logic [XLEN-1:0] trap_tval,
   input  logic [XLEN-1:0] trap_pc,
   input  logic            mret,
   input  logic            retire,
   input  logic            ext_meip,
   input  logic            ext_mtip,
   input  logic            ext_msip,
   output logic            irq_take,
   output logic [XLEN-1:0] irq_cause,
   output logic            redirect,
   output logic [XLEN-1:0] redirect_pc
);

   // Bits of mstatus that are hardwired (UXL/SXL on RV64, zero otherwise)
   localparam logic [XLEN-1:0] C_MSTATUS_FIXED =
      XLEN'(((XLEN == 64) ? C_MSTATUS_RST64 : C_MSTATUS_RST32) & ~C_MSTATUS_WMASK);
   localparam logic [XLEN-1:0] C_MSTATUS_WR  = XLEN'(C_MSTATUS_WMASK);
   // mtvec[1] is never writable; mtvec[0] only when vectored mode is offered
   localparam logic [XLEN-1:0] C_MTVEC_MASK  = VECTORED ? ~XLEN'(2) : ~XLEN'(3);
   localparam logic [XLEN-1:0] C_MEPC_MASK   = ~XLEN'(1);

   // State
   logic            r_mstatus_mie;
   logic            r_mstatus_mpie;
   logic [1:0]      r_mstatus_mpp;
   logic [XLEN-1:0] r_mie;
   logic [XLEN-1:0] r_mtvec;
   logic [XLEN-1:0] r_mscratch;
   logic [XLEN-1:0] r_mepc;
   logic [XLEN-1:0] r_mcause;
   logic [XLEN-1:0] r_mtval;
   logic [63:0]     r_mcycle;
   logic [63:0]     r_minstret;

   // Combinational
   logic            w_meip;
   logic            w_mtip;
   logic            w_msip;
   logic [XLEN-1:0] w_mip;
   logic [XLEN-1:0] w_mstatus;
   logic [XLEN-1:0] w_wr_old;
   logic [XLEN-1:0] w_wr_new;
   logic [63:0]     w_wr_new64;
   logic [XLEN-1:0] w_wr_view;
   logic            w_wr_active;
   logic            w_wr_do;
   logic [11:0]     w_pend;
   logic [XLEN-1:0] w_mtvec_base;

   // ------------------------------------------------------------------------
   // Interrupt line synchronisers
   // ------------------------------------------------------------------------
   ysyx_040066_sync2 u_sync_meip (.clk(clk), .rst(rst), .i_d(ext_meip), .o_q(w_meip));
   ysyx_040066_sync2 u_sync_mtip (.clk(clk), .rst(rst), .i_d(ext_mtip), .o_q(w_mtip));
   ysyx_040066_sync2 u_sync_msip (.clk(clk), .rst(rst), .i_d(ext_msip), .o_q(w_msip));

   always_comb begin
      w_mip             = '0;
      w_mip[C_IRQ_MEI]  = w_meip;
      w_mip[C_IRQ_MTI]  = w_mtip;
      w_mip[C_IRQ_MSI]  = w_msip;
   end

   always_comb begin
      w_mstatus                                     = C_MSTATUS_FIXED;
      w_mstatus[C_MSTATUS_MIE]                      = r_mstatus_mie;
      w_mstatus[C_MSTATUS_MPIE]                     = r_mstatus_mpie;
      w_mstatus[C_MSTATUS_MPP_HI:C_MSTATUS_MPP_LO]  = r_mstatus_mpp;
   end

   // ------------------------------------------------------------------------
   // CSR decode helpers
   // ------------------------------------------------------------------------
   function automatic logic csr_exists(input logic [11:0] addr);
      logic ok;
      case (addr)
         C_CSR_MSTATUS, C_CSR_MIE, C_CSR_MTVEC, C_CSR_MSCRATCH, C_CSR_MEPC,
         C_CSR_MCAUSE, C_CSR_MTVAL, C_CSR_MIP, C_CSR_MCYCLE, C_CSR_MINSTRET,
         C_CSR_MHARTID:                    ok = 1'b1;
         C_CSR_MCYCLEH, C_CSR_MINSTRETH:   ok = (XLEN == 32);
         default:                          ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [XLEN-1:0] csr_read(input logic [11:0] addr);
      logic [XLEN-1:0] v;
      case (addr)
         C_CSR_MSTATUS:   v = w_mstatus;
         C_CSR_MIE:       v = r_mie;
         C_CSR_MTVEC:     v = r_mtvec;
         C_CSR_MSCRATCH:  v = r_mscratch;
         C_CSR_MEPC:      v = r_mepc;
         C_CSR_MCAUSE:    v = r_mcause;
         C_CSR_MTVAL:     v = r_mtval;
         C_CSR_MIP:       v = w_mip;
         C_CSR_MCYCLE:    v = r_mcycle[XLEN-1:0];
         C_CSR_MINSTRET:  v = r_minstret[XLEN-1:0];
         C_CSR_MCYCLEH:   v = (XLEN == 32) ? XLEN'(r_mcycle[63:32]) : '0;
         C_CSR_MINSTRETH: v = (XLEN == 32) ? XLEN'(r_minstret[63:32]) : '0;
         C_CSR_MHARTID:   v = XLEN'(HART_ID);
         default:         v = '0;
      endcase
      return v;
   endfunction

   // ------------------------------------------------------------------------
   // Write path
   // ------------------------------------------------------------------------
   assign w_wr_active = wr_en && (wr_op != CSR_OP_NOP);
   assign wr_illegal  = w_wr_active && (!csr_exists(wr_addr) || (wr_addr == C_CSR_MHARTID));
   // Trap and mret pre-empt any CSR write in the same cycle
   assign w_wr_do     = w_wr_active && !wr_illegal && !trap && !mret;
   assign w_wr_old    = csr_read(wr_addr);

   always_comb begin
      case (wr_op)
         CSR_OP_RW: w_wr_new = wr_src;
         CSR_OP_RS: w_wr_new = w_wr_old | wr_src;
         CSR_OP_RC: w_wr_new = w_wr_old & ~wr_src;
         default:   w_wr_new = w_wr_old;
      endcase
   end

   assign w_wr_new64 = 64'(w_wr_new);

   // Value the written CSR will read back once the write lands (after WARL)
   always_comb begin
      case (wr_addr)
         C_CSR_MSTATUS: w_wr_view = C_MSTATUS_FIXED | (w_wr_new & C_MSTATUS_WR);
         C_CSR_MTVEC:   w_wr_view = w_wr_new & C_MTVEC_MASK;
         C_CSR_MEPC:    w_wr_view = w_wr_new & C_MEPC_MASK;
         C_CSR_MIP:     w_wr_view = w_mip;
         default:       w_wr_view = w_wr_new;
      endcase
   end

   assign rd_data    = (w_wr_do && (rd_addr == wr_addr)) ? w_wr_view : csr_read(rd_addr);
   assign rd_illegal = !csr_exists(rd_addr);

   // ------------------------------------------------------------------------
   // Redirect
   // ------------------------------------------------------------------------
   assign w_mtvec_base = r_mtvec & ~XLEN'(3);
   assign redirect     = trap | mret;

   always_comb begin
      if (trap) begin
         if (r_mtvec[0] && trap_cause[XLEN-1])
            redirect_pc = w_mtvec_base + {trap_cause[XLEN-3:0], 2'b00};
         else
            redirect_pc = w_mtvec_base;
      end else if (mret) begin
         redirect_pc = r_mepc;
      end else begin
         redirect_pc = '0;
      end
   end

   // ------------------------------------------------------------------------
   // Interrupt arbitration
   // ------------------------------------------------------------------------
   assign w_pend   = w_mip[11:0] & r_mie[11:0] & C_IRQ_MASK;
   assign irq_take = r_mstatus_mie & (|w_pend);

   always_comb begin
      irq_cause = '0;
      if (irq_take) begin
         irq_cause[XLEN-1] = 1'b1;
         irq_cause[3:0]    = irq_pick(w_pend);
      end
   end

   // ------------------------------------------------------------------------
   // State update
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mstatus_mie  <= 1'b0;
         r_mstatus_mpie <= 1'b0;
         r_mstatus_mpp  <= 2'b11;
         r_mie          <= '0;
         r_mtvec        <= '0;
         r_mscratch     <= '0;
         r_mepc         <= '0;
         r_mcause       <= '0;
         r_mtval        <= '0;
         r_mcycle       <= '0;
         r_minstret     <= '0;
      end else begin
         // Free-running increments; a CSR write below overrides them
         r_mcycle <= r_mcycle + 64'd1;
         if (retire)
            r_minstret <= r_minstret + 64'd1;

         if (trap) begin
            r_mepc         <= trap_pc & C_MEPC_MASK;
            r_mcause       <= trap_cause;
            r_mtval        <= trap_tval;
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpp  <= 2'b11;
         end else if (mret) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
            r_mstatus_mpp  <= 2'b00;
         end else if (w_wr_do) begin
            case (wr_addr)
               C_CSR_MSTATUS: begin
                  r_mstatus_mie  <= w_wr_new[C_MSTATUS_MIE];
                  r_mstatus_mpie <= w_wr_new[C_MSTATUS_MPIE];
                  r_mstatus_mpp  <= w_wr_new[C_MSTATUS_MPP_HI:C_MSTATUS_MPP_LO];
               end
               C_CSR_MIE:       r_mie      <= w_wr_new;
               C_CSR_MTVEC:     r_mtvec    <= w_wr_new & C_MTVEC_MASK;
               C_CSR_MSCRATCH:  r_mscratch <= w_wr_new;
               C_CSR_MEPC:      r_mepc     <= w_wr_new & C_MEPC_MASK;
               C_CSR_MCAUSE:    r_mcause   <= w_wr_new;
               C_CSR_MTVAL:     r_mtval    <= w_wr_new;
               C_CSR_MCYCLE:
                  r_mcycle <= (XLEN == 64) ? w_wr_new64
                                           : {r_mcycle[63:32], w_wr_new64[31:0]};
               C_CSR_MINSTRET:
                  r_minstret <= (XLEN == 64) ? w_wr_new64
                                             : {r_minstret[63:32], w_wr_new64[31:0]};
               C_CSR_MCYCLEH:   r_mcycle   <= {w_wr_new64[31:0], r_mcycle[31:0]};
               C_CSR_MINSTRETH: r_minstret <= {w_wr_new64[31:0], r_minstret[31:0]};
               default: ;
            endcase
         end
      end
   end

endmodule
`default_nettype wire
